// File: rtl/snn_layer_scheduler.sv
//============================================================================
// Module      : snn_layer_scheduler
// Description : Time-multiplexed integrate-and-fire layer. One shared
//               accumulate/fire datapath serves NUM_OUT neurons fed by
//               NUM_IN spike lines. It runs T_WINDOW timesteps, counts
//               spikes per neuron and reports the winning neuron.
//               Optional macro REFRACTORY_EN adds per-neuron refractory
//               periods of REFRAC_STEPS timesteps.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module snn_layer_scheduler #(
    parameter int                 NUM_IN       = 4,
    parameter int                 NUM_OUT      = 4,
    parameter int                 T_WINDOW     = 250,
    parameter logic signed [15:0] THRESHOLD    = 16'sh00F0,
    parameter int                 CNT_W        = 8,
    parameter int                 REFRAC_STEPS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [NUM_IN-1:0]                    in_spikes,
    output logic [$clog2(NUM_OUT*NUM_IN)-1:0]    w_addr,
    input  logic signed [15:0]                   w_data,
    output logic [NUM_OUT-1:0]                   out_spikes,
    output logic                                 step_valid,
    output logic                                 busy,
    output logic                                 done,
    output logic [$clog2(NUM_OUT)-1:0]           winner,
    output logic [CNT_W-1:0]                     winner_cnt
);

    localparam int c_AW = $clog2(NUM_OUT*NUM_IN);
    localparam int c_OW = $clog2(NUM_OUT);
    localparam int c_IW = $clog2(NUM_IN+1);
    localparam int c_TW = (T_WINDOW > 1) ? $clog2(T_WINDOW) : 1;

    localparam logic [c_IW-1:0]   c_I_LAST  = c_IW'(NUM_IN);
    localparam logic [c_OW-1:0]   c_O_LAST  = c_OW'(NUM_OUT-1);
    localparam logic [c_TW-1:0]   c_T_LAST  = c_TW'(T_WINDOW-1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;
    localparam logic signed [20:0] c_POS_LIM = 21'sd32767;
    localparam logic signed [20:0] c_NEG_LIM = -21'sd32768;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_ACCUM = 3'd2;
    localparam logic [2:0] c_FIRE  = 3'd3;
    localparam logic [2:0] c_NEXT  = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    logic [2:0]               r_state;
    logic [NUM_IN-1:0]        r_spk;
    logic [c_OW-1:0]          r_o;
    logic [c_IW-1:0]          r_i;
    logic signed [19:0]       r_sum;
    logic signed [15:0]       r_pot [NUM_OUT];
    logic [CNT_W-1:0]         r_cnt [NUM_OUT];
    logic [NUM_OUT-1:0]       r_spk_next;
    logic [c_TW-1:0]          r_t;
    logic [NUM_OUT-1:0]       r_out_spikes;
    logic                     r_step_valid;
    logic                     r_busy;
    logic                     r_done;
    logic [c_OW-1:0]          r_winner;
    logic [CNT_W-1:0]         r_winner_cnt;

    logic [c_AW-1:0]          w_rom_addr;
    logic [NUM_IN:0]          w_spk_ext;
    logic                     w_spk_bit;
    logic signed [15:0]       w_pot_cur;
    logic signed [20:0]       w_sum_wide;
    logic signed [15:0]       w_new;
    logic                     w_fire;
    logic                     w_blocked;
    logic [c_OW-1:0]          w_best;
    logic [CNT_W-1:0]         w_best_cnt;

`ifdef REFRACTORY_EN
    localparam int c_RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS+1) : 1;
    localparam logic [c_RW-1:0] c_REFRAC = c_RW'(REFRAC_STEPS);
    logic [c_RW-1:0] r_ref [NUM_OUT];
    assign w_blocked = (r_ref[r_o] != '0);
`else
    assign w_blocked = 1'b0;
`endif

    // Weight address is only driven while fetching inputs 0..NUM_IN-1
    always_comb begin
        w_rom_addr = '0;
        if (r_state == c_ACCUM && r_i != c_I_LAST) begin
            w_rom_addr = c_AW'(int'(r_o) * NUM_IN + int'(r_i));
        end
    end

    // Data for input i arrives when r_i == i+1; bit 0 pads the first fetch cycle
    assign w_spk_ext = {r_spk, 1'b0};
    assign w_spk_bit = w_spk_ext[r_i];

    // Saturating potential update and threshold compare for the current neuron
    always_comb begin
        w_pot_cur  = r_pot[r_o];
        w_sum_wide = {{5{w_pot_cur[15]}}, w_pot_cur} + {r_sum[19], r_sum};
        if (w_sum_wide > c_POS_LIM) begin
            w_new = 16'sh7FFF;
        end else if (w_sum_wide < c_NEG_LIM) begin
            w_new = -16'sh8000;
        end else begin
            w_new = w_sum_wide[15:0];
        end
        w_fire = (w_new >= THRESHOLD);
    end

    // Argmax over spike counts; strict compare keeps the lowest index on ties
    always_comb begin
        w_best     = '0;
        w_best_cnt = r_cnt[0];
        for (int k = 1; k < NUM_OUT; k++) begin
            if (r_cnt[k] > w_best_cnt) begin
                w_best_cnt = r_cnt[k];
                w_best     = c_OW'(k);
            end
        end
    end

    // Scheduler FSM and neuron state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_spk        <= '0;
            r_o          <= '0;
            r_i          <= '0;
            r_sum        <= '0;
            r_spk_next   <= '0;
            r_t          <= '0;
            r_out_spikes <= '0;
            r_step_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_winner     <= '0;
            r_winner_cnt <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                r_pot[k] <= '0;
                r_cnt[k] <= '0;
`ifdef REFRACTORY_EN
                r_ref[k] <= '0;
`endif
            end
        end else begin
            r_step_valid <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // The done cycle still counts as part of the run, so start is ignored there
                    if (start && !r_done) begin
                        r_t        <= '0;
                        r_spk_next <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= c_LOAD;
                        for (int k = 0; k < NUM_OUT; k++) begin
                            r_pot[k] <= '0;
                            r_cnt[k] <= '0;
`ifdef REFRACTORY_EN
                            r_ref[k] <= '0;
`endif
                        end
                    end
                end
                c_LOAD: begin
                    r_spk   <= in_spikes;
                    r_o     <= '0;
                    r_i     <= '0;
                    r_sum   <= '0;
                    r_state <= c_ACCUM;
                end
                c_ACCUM: begin
                    if (w_spk_bit) begin
                        r_sum <= r_sum + {{4{w_data[15]}}, w_data};
                    end
                    if (r_i == c_I_LAST) begin
                        r_state <= c_FIRE;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                c_FIRE: begin
                    if (w_blocked) begin
                        r_pot[r_o]      <= '0;
                        r_spk_next[r_o] <= 1'b0;
                    end else if (w_fire) begin
                        r_pot[r_o]      <= '0;
                        r_spk_next[r_o] <= 1'b1;
                        if (r_cnt[r_o] != c_CNT_MAX) begin
                            r_cnt[r_o] <= r_cnt[r_o] + 1'b1;
                        end
`ifdef REFRACTORY_EN
                        r_ref[r_o] <= c_REFRAC;
`endif
                    end else begin
                        r_pot[r_o]      <= w_new;
                        r_spk_next[r_o] <= 1'b0;
                    end
                    r_sum <= '0;
                    r_i   <= '0;
                    if (r_o == c_O_LAST) begin
                        r_state <= c_NEXT;
                    end else begin
                        r_o     <= r_o + 1'b1;
                        r_state <= c_ACCUM;
                    end
                end
                c_NEXT: begin
                    r_out_spikes <= r_spk_next;
                    r_step_valid <= 1'b1;
`ifdef REFRACTORY_EN
                    // A neuron that fired this step keeps its full refractory count
                    for (int k = 0; k < NUM_OUT; k++) begin
                        if (r_ref[k] != '0 && !r_spk_next[k]) begin
                            r_ref[k] <= r_ref[k] - 1'b1;
                        end
                    end
`endif
                    if (r_t == c_T_LAST) begin
                        r_state <= c_DONE;
                    end else begin
                        r_t     <= r_t + 1'b1;
                        r_state <= c_LOAD;
                    end
                end
                c_DONE: begin
                    r_winner     <= w_best;
                    r_winner_cnt <= w_best_cnt;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign w_addr     = w_rom_addr;
    assign out_spikes = r_out_spikes;
    assign step_valid = r_step_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign winner     = r_winner;
    assign winner_cnt = r_winner_cnt;

endmodule

`default_nettype wire

// File: tb/tb_snn_layer_scheduler.sv
//============================================================================
// Module      : tb_snn_layer_scheduler
// Description : Self-checking bench for snn_layer_scheduler. Two instances:
//               default parameters (A) and CNT_W=6 (B). Weight ROMs are
//               modelled with one cycle of read latency.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_snn_layer_scheduler;

`ifdef REFRACTORY_EN
    localparam bit c_REFRAC = 1'b1;
    localparam int c_EXP_SINGLE = 50;
    localparam int c_EXP_SAT    = 84;
    localparam int c_EXP_EVERY  = 84;
`else
    localparam bit c_REFRAC = 1'b0;
    localparam int c_EXP_SINGLE = 83;
    localparam int c_EXP_SAT    = 250;
    localparam int c_EXP_EVERY  = 250;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst = 1'b1;
    logic               start_a = 1'b0;
    logic               start_b = 1'b0;
    logic [3:0]         in_spikes = 4'b0000;
    logic [3:0]         w_addr_a, w_addr_b;
    logic signed [15:0] w_data_a, w_data_b;
    logic [3:0]         out_a, out_b;
    logic               sv_a, sv_b, busy_a, busy_b, done_a, done_b;
    logic [1:0]         win_a, win_b;
    logic [7:0]         wc_a;
    logic [5:0]         wc_b;

    logic signed [15:0] rom_a [16];
    logic signed [15:0] rom_b [16];

    snn_layer_scheduler u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_spikes(in_spikes),
        .w_addr(w_addr_a), .w_data(w_data_a), .out_spikes(out_a),
        .step_valid(sv_a), .busy(busy_a), .done(done_a),
        .winner(win_a), .winner_cnt(wc_a)
    );

    snn_layer_scheduler #(.CNT_W(6)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_spikes(in_spikes),
        .w_addr(w_addr_b), .w_data(w_data_b), .out_spikes(out_b),
        .step_valid(sv_b), .busy(busy_b), .done(done_b),
        .winner(win_b), .winner_cnt(wc_b)
    );

    // Synchronous weight ROMs: data one cycle after address
    always @(posedge clk) begin
        w_data_a <= rom_a[w_addr_a];
        w_data_b <= rom_b[w_addr_b];
    end

    logic       sel = 1'b0;
    logic [3:0] m_out;
    logic       m_sv, m_busy, m_done;
    logic [1:0] m_win;
    logic [7:0] m_wc;

    always_comb begin
        m_out  = sel ? out_b  : out_a;
        m_sv   = sel ? sv_b   : sv_a;
        m_busy = sel ? busy_b : busy_a;
        m_done = sel ? done_b : done_a;
        m_win  = sel ? win_b  : win_a;
        m_wc   = sel ? {2'b00, wc_b} : wc_a;
    end

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q [$];

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_rom(input int cfg);
        for (int k = 0; k < 16; k++) begin
            rom_a[k] = 16'sh0000;
            rom_b[k] = 16'sh0000;
        end
        case (cfg)
            0: rom_a[0] = 16'sh0050;
            1: begin
                for (int k = 12; k < 16; k++) rom_a[k] = -16'sh4000;
                for (int k = 8;  k < 11; k++) rom_a[k] = -16'sh4000;
                for (int k = 4;  k < 8;  k++) rom_a[k] = 16'sh7000;
            end
            2: begin
                rom_b[4] = 16'sh00F0;
                rom_b[8] = 16'sh00F0;
            end
            3: rom_a[0] = 16'sh00F0;
            default: ;
        endcase
    endtask

    // Timestep-level reference: push the expected spike vector of every step
    task automatic model_push(input logic s, input logic [3:0] spk);
        int pot [4];
        int refc [4];
        int sum, nv;
        logic [3:0] v;
        exp_q.delete();
        for (int o = 0; o < 4; o++) begin
            pot[o]  = 0;
            refc[o] = 0;
        end
        for (int t = 0; t < 250; t++) begin
            v = 4'b0000;
            for (int o = 0; o < 4; o++) begin
                sum = 0;
                for (int i = 0; i < 4; i++) begin
                    if (spk[i]) sum += s ? int'(rom_b[o*4+i]) : int'(rom_a[o*4+i]);
                end
                if (c_REFRAC && refc[o] != 0) begin
                    pot[o] = 0;
                end else begin
                    nv = pot[o] + sum;
                    if (nv > 32767)  nv = 32767;
                    if (nv < -32768) nv = -32768;
                    if (nv >= 240) begin
                        v[o]    = 1'b1;
                        pot[o]  = 0;
                        refc[o] = 2;
                    end else begin
                        pot[o] = nv;
                    end
                end
            end
            for (int o = 0; o < 4; o++) begin
                if (refc[o] != 0 && !v[o]) refc[o]--;
            end
            exp_q.push_back(v);
        end
    endtask

    task automatic pulse_rst(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_run(input logic s, input logic [3:0] spk, input int cfg,
                          input int ew, input int ec, input bit abuse);
        int n, steps, last, extra;
        logic [3:0] v;
        bit got_done;
        set_rom(cfg);
        sel       = s;
        in_spikes = spk;
        model_push(s, spk);
        @(posedge clk); #1;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        n = 0; steps = 0; last = 0; got_done = 1'b0;
        while (!got_done && n < 7000) begin
            @(posedge clk); #1;
            n++;
            start_a = 1'b0;
            start_b = 1'b0;
            if (abuse && n == 9) begin
                if (s) start_b = 1'b1; else start_a = 1'b1;
            end
            if (n == 1) check("busy_after_start", m_busy, 1);
            if (m_sv) begin
                steps++;
                if (exp_q.size() == 0) begin
                    check("step_extra", steps, 250);
                end else begin
                    v = exp_q.pop_front();
                    check("step_spikes", m_out, v);
                end
                if (steps == 1) check("first_step_cycle", n, 27);
                else            check("step_period", n - last, 26);
                last = n;
            end
            if (m_done) got_done = 1'b1;
        end
        check("done_latency", n, 6502);
        check("step_count", steps, 250);
        check("busy_in_done", m_busy, 0);
        check("winner", m_win, ew);
        check("winner_cnt", m_wc, ec);
        if (abuse) begin
            if (s) start_b = 1'b1; else start_a = 1'b1;
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check("done_one_cycle", m_done, 0);
        check("busy_after_done", m_busy, 0);
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (m_done || m_busy) extra++;
        end
        check("no_rerun_after_done", extra, 0);
        check("winner_hold", m_win, ew);
        check("winner_cnt_hold", m_wc, ec);
    endtask

    typedef struct {
        logic       s;
        logic [3:0] spk;
        int         cfg;
        int         ew;
        int         ec;
        bit         abuse;
        bit         pre_rst;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int n, hits;

        tbl[0] = '{1'b0, 4'b0001, 0, 0, c_EXP_SINGLE, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 4'b1111, 1, 1, c_EXP_SAT,    1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'b0000, 1, 0, 0,            1'b0, 1'b1};
        tbl[3] = '{1'b1, 4'b0001, 2, 1, 63,           1'b0, 1'b0};
        tbl[4] = '{1'b0, 4'b0001, 3, 0, c_EXP_EVERY,  1'b0, 1'b0};

        set_rom(-1);

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (sv_a || sv_b) hits++;
        end
        check("rst_step_valid", hits, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_out_a", out_a, 0);
        check("rst_winner_a", win_a, 0);
        check("rst_wcnt_a", wc_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_wcnt_b", wc_b, 0);

        // Main table: one full run per entry
        for (int r = 0; r < 5; r++) begin
            if (tbl[r].pre_rst) pulse_rst(2);
            do_run(tbl[r].s, tbl[r].spk, tbl[r].cfg, tbl[r].ew, tbl[r].ec, tbl[r].abuse);
        end

        // Reset in the middle of a run
        set_rom(3);
        sel       = 1'b0;
        in_spikes = 4'b0001;
        @(posedge clk); #1;
        start_a = 1'b1;
        n = 0;
        while (n < 2999) begin
            @(posedge clk); #1;
            n++;
            start_a = 1'b0;
        end
        check("busy_before_rst", busy_a, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("busy_after_midrun_rst", busy_a, 0);
        check("wcnt_after_midrun_rst", wc_a, 0);
        rst = 1'b0;
        hits = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (done_a || sv_a || busy_a) hits++;
        end
        check("no_activity_after_rst", hits, 0);

        // Counts must start from zero after the aborted run
        do_run(1'b0, 4'b0001, 0, 0, c_EXP_SINGLE, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/snn_layer_scheduler.md
Name: snn_layer_scheduler

Overview:
- Time-multiplexed scheduler that shares one accumulate-and-fire datapath across NUM_OUT leaky-free integrate-and-fire neurons fed by NUM_IN input spike lines.
- Sequences every neuron once per timestep, over a window of T_WINDOW timesteps.
- Counts output spikes per neuron and reports the winning neuron at the end of the window.
- Sits between the input_neuron encoders and the classification readout, replacing per-neuron instances.

Parameters:
- NUM_IN, 4: number of input spike lines.
- NUM_OUT, 4: number of output neurons.
- T_WINDOW, 250: timesteps per run.
- THRESHOLD, 16'sh00F0: signed firing threshold.
- CNT_W, 8: width of each per-neuron spike counter.
- REFRAC_STEPS, 2: refractory timesteps; used only with REFRACTORY_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; ignored while busy.
- in_spikes  in  NUM_IN  input spikes; sampled only in LOAD.
- w_addr  out  clog2(NUM_OUT*NUM_IN)  weight ROM address = o*NUM_IN+i.
- w_data  in  16 signed  weight; valid exactly 1 cycle after w_addr.
- out_spikes  out  NUM_OUT  spike vector of the last completed timestep.
- step_valid  out  1  one-cycle pulse when out_spikes updates.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse; winner outputs are valid from this cycle.
- winner  out  clog2(NUM_OUT)  index of the neuron with the highest count.
- winner_cnt  out  CNT_W  spike count of the winner.

Behaviour:
- Reset: FSM to IDLE. All outputs 0; potentials, counters, timestep counter and accumulator all 0. Reset mid-run aborts the run with no done pulse.
- IDLE: on start, clear potentials, counters and t_cnt, then go to LOAD. busy=1 from the next cycle.
- LOAD (1 cycle): latch in_spikes into spk_reg; set o=0, i=0, sum=0.
- ACCUM (NUM_IN+1 cycles per neuron):
  - Cycles 0..NUM_IN-1 issue w_addr for i=0..NUM_IN-1.
  - Cycles 1..NUM_IN add w_data to sum when spk_reg[i]=1.
  - sum is 20-bit signed.
- FIRE (1 cycle per neuron):
  - new = pot[o] + sum, saturated to the 16-bit signed range [-32768, 32767]; no wrap-around.
  - If new >= THRESHOLD: spk_next[o]=1, pot[o]=0, count[o] increments, saturating at 2^CNT_W-1.
  - Else: pot[o]=new, spk_next[o]=0.
  - If o<NUM_OUT-1: o++ and return to ACCUM. Else go to NEXT.
- NEXT (1 cycle): out_spikes<=spk_next; step_valid=1. If t_cnt==T_WINDOW-1 go to DONE; else t_cnt++ and go to LOAD.
- Timestep length is 2+NUM_OUT*(NUM_IN+2) cycles (26 at defaults).
- DONE (1 cycle):
  - winner = index of the maximum count; ties go to the lowest index. All-zero counts give winner=0, winner_cnt=0.
  - done=1 and busy=0 in this same cycle, then return to IDLE.
  - winner and winner_cnt hold until the next start.
- start asserted in DONE or any busy state is ignored. start in IDLE is accepted the same cycle.
- Latency at defaults: done asserts 1+250*26+1 = 6502 cycles after the start edge.

Optional Feature:
- Macro: REFRACTORY_EN.
- Defined:
  - Each neuron has a counter set to REFRAC_STEPS when it fires, decremented once per timestep in NEXT.
  - While the counter is nonzero, FIRE forces pot[o]=0 and spk_next[o]=0, and the counter does not increment.
  - The ACCUM cycles still run, so timestep length is unchanged.
- Undefined: no refractory logic; a neuron may fire on every timestep.

Test Plan:
- Reset check: hold rst 3 cycles, then release without start -> busy=0, done=0, out_spikes=0, winner=0, winner_cnt=0, step_valid never pulses.
- Single path: in_spikes=4'b0001 constant, w[0][0]=16'h0050, all other weights 0 -> neuron 0 fires on timesteps 2,5,...,248. done at cycle 6502 with winner=0, winner_cnt=83. step_valid pulses 250 times, every 26 cycles.
- Saturation: in_spikes=4'b1111, all weights to neuron 3 = -16'sh4000 -> pot[3] clamps at -32768 with no positive wrap and no spikes. Then rst, and a 4'b0000 run -> winner=0, winner_cnt=0.
- Tie and counter saturation: CNT_W=6, w[1][0]=w[2][0]=16'h00F0, in_spikes=4'b0001 -> neurons 1 and 2 fire every timestep, counts saturate at 63, winner=1, winner_cnt=63.
- Control abuse: pulse start again at cycles 10 and 6502 -> both ignored, one done only. Assert rst at cycle 3000 -> busy=0 next cycle, no done, next run's counts start from 0.
- REFRACTORY_EN, REFRAC_STEPS=2, w[0][0]=16'h00F0, in_spikes=4'b0001 -> neuron 0 fires on timesteps 0,3,...,249, winner_cnt=84.
